// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit:
// funct3 op encodings, FSM state type and width constants.
package mdu_pkg;

  localparam int MDU_XLEN = 32;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } state_t;

endpackage

// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: one radix-2 step per clock over a
// shared 2*XLEN shift register, followed by a sign-fix/select cycle.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int XLEN  = MDU_XLEN,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] I1,
  input  logic [XLEN-1:0] I2,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic            N,
  output logic            Z
);

  state_t              state;
  logic [2:0]          op_q;
  logic [CNT_W-1:0]    count;
  logic [2*XLEN-1:0]   prod;
  logic [XLEN-1:0]     opnd;
  logic                neg;

  logic                signed_a, signed_b, neg_a, neg_b;
  logic                is_div, div_zero, div_ovf, is_rem;
  logic [XLEN-1:0]     mag_a, mag_b;

  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       div_shift, div_diff;
  logic [2*XLEN-1:0]   div_next;

  logic [2*XLEN-1:0]   prod_fix;
  logic [XLEN-1:0]     rem_fix;
  logic [XLEN-1:0]     fix_val;

  always_comb begin
    signed_a = (op == MDU_MULH) || (op == MDU_MULHSU) || (op == MDU_DIV) || (op == MDU_REM);
    signed_b = (op == MDU_MULH) || (op == MDU_DIV) || (op == MDU_REM);
    neg_a    = signed_a & I1[XLEN-1];
    neg_b    = signed_b & I2[XLEN-1];
    mag_a    = neg_a ? -I1 : I1;
    mag_b    = neg_b ? -I2 : I2;
    is_div   = op[2];
    is_rem   = (op == MDU_REM) || (op == MDU_REMU);
    div_zero = is_div && (I2 == '0);
    div_ovf  = ((op == MDU_DIV) || (op == MDU_REM)) && (I1 == XLEN'(INT_MIN)) && (I2 == '1);
  end

  // Multiply: conditional add into the high half, then shift the whole product right.
  // Divide: upper half is the remainder, lower half shifts dividend out and quotient in.
  always_comb begin
    mul_sum   = {1'b0, prod[2*XLEN-1:XLEN]} + (prod[0] ? {1'b0, opnd} : '0);
    div_shift = {prod[2*XLEN-1:XLEN], prod[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd};
    if (!div_diff[XLEN])
      div_next = {div_diff[XLEN-1:0], prod[XLEN-2:0], 1'b1};
    else
      div_next = {div_shift[XLEN-1:0], prod[XLEN-2:0], 1'b0};
  end

  // The high product half needs the full-width negate; the remainder negates on its own.
  always_comb begin
    prod_fix = neg ? -prod : prod;
    rem_fix  = neg ? -prod[2*XLEN-1:XLEN] : prod[2*XLEN-1:XLEN];
    case (op_q)
      MDU_MUL:                         fix_val = prod_fix[XLEN-1:0];
      MDU_MULH, MDU_MULHSU, MDU_MULHU: fix_val = prod_fix[2*XLEN-1:XLEN];
      MDU_DIV, MDU_DIVU:               fix_val = prod_fix[XLEN-1:0];
      default:                         fix_val = rem_fix;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= '0;
      count  <= '0;
      prod   <= '0;
      opnd   <= '0;
      neg    <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      N      <= 1'b0;
      Z      <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q  <= op;
            busy  <= 1'b1;
            count <= '0;
            // {I1, ones} serves both divide-by-zero answers: remainder high, quotient low.
            if (div_zero) begin
              prod  <= {I1, {XLEN{1'b1}}};
              neg   <= 1'b0;
              state <= FIX;
            end else if (div_ovf) begin
              prod  <= {{XLEN{1'b0}}, XLEN'(INT_MIN)};
              neg   <= 1'b0;
              state <= FIX;
            end else begin
              opnd  <= is_div ? mag_b : mag_a;
              prod  <= {{XLEN{1'b0}}, (is_div ? mag_a : mag_b)};
              neg   <= is_rem ? neg_a : (neg_a ^ neg_b);
              state <= CALC;
            end
          end
        end
        CALC: begin
          prod  <= op_q[2] ? div_next : {mul_sum, prod[XLEN-1:1]};
          count <= count + 1'b1;
          if (count == CNT_W'(XLEN-1))
            state <= FIX;
        end
        FIX: begin
          result <= fix_val;
          N      <= fix_val[XLEN-1];
          Z      <= (fix_val == '0);
          done   <= 1'b1;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
